// File: rtl/cfg_loader_pkg.sv
// Shared constants and helpers for the configuration-chain loader.
// Holds the FSM state encodings, the word-count derivation, a counter-width
// helper and the default chain geometry shared with the core.
package cfg_loader_pkg;

   localparam int unsigned DEF_NUM_BITS = 4416;
   localparam int unsigned DEF_WORD_W   = 32;

   // Loader FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CRST   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Words needed to carry nb chain bits in ww-bit words
   function automatic int unsigned num_words(input int unsigned nb, input int unsigned ww);
      return (nb + ww - 1) / ww;
   endfunction

   // Bits needed for a counter that reaches max_val
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/cfg_stream_loader_if.sv
// Bitstream word stream: valid/ready handshake carrying one word per transfer.
// master drives s_data/s_valid, slave returns s_ready.
interface cfg_stream_loader_if
   import cfg_loader_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W
);
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cfg_word_serializer.sv
// Word-to-bit serializer: one-word holding register feeding a shift register.
// Ports: clk/rst_n; clear re-arms for a new pass; active = FSM in STREAM this
// cycle, active_next = FSM in STREAM next cycle; s_data/s_valid/s_ready word
// handshake; bit_out/bit_en registered serial bit and enable; last_c is high
// in the cycle that presents the final chain bit.
module cfg_word_serializer
   import cfg_loader_pkg::*;
#(
   parameter int unsigned NUM_BITS = DEF_NUM_BITS,
   parameter int unsigned WORD_W   = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              active,
   input  logic              active_next,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              bit_out,
   output logic              bit_en,
   output logic              last_c
);
   localparam int unsigned NUM_WORDS = num_words(NUM_BITS, WORD_W);
   localparam int unsigned BIT_CW    = cnt_w(NUM_BITS);
   localparam int unsigned WORD_CW   = cnt_w(NUM_WORDS);
   localparam int unsigned SH_CW     = cnt_w(WORD_W);

   logic [WORD_W-1:0]  hold;
   logic               hold_full;
   logic [WORD_W-1:0]  shreg;
   logic [SH_CW-1:0]   sh_left;
   logic [WORD_CW-1:0] words;
   logic [BIT_CW-1:0]  bits_left;

   logic               present_c;
   logic               refill_c;
   logic               take_c;
   logic               hold_full_nx;
   logic [WORD_CW-1:0] words_nx;
   logic               ready_nx;

   // A bit goes out whenever the pass is unfinished and shreg or hold has data;
   // an empty shreg refills from hold in the same cycle so streaming is gapless.
   assign present_c    = active && (bits_left != '0) && ((sh_left != '0) || hold_full);
   assign refill_c     = present_c && (sh_left == '0);
   assign take_c       = s_valid && s_ready;
   assign last_c       = present_c && (bits_left == BIT_CW'(1));
   assign hold_full_nx = take_c || (hold_full && !refill_c);
   assign words_nx     = words + WORD_CW'(take_c);
   assign ready_nx     = !hold_full_nx && active_next && (words_nx < WORD_CW'(NUM_WORDS));

   // Datapath registers; a take and a refill in one cycle read the old hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
         shreg     <= '0;
         sh_left   <= '0;
         words     <= '0;
         bits_left <= '0;
         s_ready   <= 1'b0;
         bit_out   <= 1'b0;
         bit_en    <= 1'b0;
      end else if (clear) begin
         hold_full <= 1'b0;
         sh_left   <= '0;
         words     <= '0;
         bits_left <= BIT_CW'(NUM_BITS);
         s_ready   <= active_next;
         bit_en    <= 1'b0;
      end else begin
         s_ready   <= ready_nx;
         bit_en    <= present_c;
         hold_full <= hold_full_nx;
         words     <= words_nx;
         if (take_c) hold <= s_data;
         if (present_c) begin
            bits_left <= bits_left - BIT_CW'(1);
            if (refill_c) begin
               bit_out <= hold[0];
               shreg   <= hold >> 1;
               sh_left <= SH_CW'(WORD_W - 1);
            end else begin
               bit_out <= shreg[0];
               shreg   <= shreg >> 1;
               sh_left <= sh_left - SH_CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/cfg_stream_loader.sv
// Configuration master for the core serial programming chain.
// Ports: prog_clk clock, rst async active-low reset; start/verify begin a
// load or a readback-compare pass; s (slave) bitstream word stream;
// prog_in/prog_en serial chain drive, prog_out chain return; core_rst
// active-low core reset; busy/done pass status; error/mismatch_cnt verify result.
module cfg_stream_loader
   import cfg_loader_pkg::*;
#(
   parameter int unsigned NUM_BITS   = DEF_NUM_BITS,
   parameter int unsigned WORD_W     = DEF_WORD_W,
   parameter int unsigned RST_CYCLES = 10,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             prog_clk,
   input  logic             rst,
   input  logic             start,
   input  logic             verify,
   cfg_stream_loader_if.slave s,
   output logic             prog_in,
   output logic             prog_en,
   input  logic             prog_out,
   output logic             core_rst,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] mismatch_cnt
);
   localparam int unsigned RST_CW = cnt_w(RST_CYCLES);

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [RST_CW-1:0] rst_cnt;
   logic              ver_q;
   logic              start_acc_c;
   logic              last_c;
   logic              ready;
   logic              core_rst_nx;
   logic              busy_nx;
   logic              done_nx;

   assign s.s_ready = ready;

   // State register
   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Next state and next registered-output values
   always_comb begin
      state_nx    = state;
      start_acc_c = 1'b0;
      core_rst_nx = 1'b1;
      busy_nx     = 1'b0;
      done_nx     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               start_acc_c = 1'b1;
               state_nx    = verify ? ST_STREAM : ST_CRST;
            end
         end
         ST_CRST:   if (rst_cnt == RST_CW'(RST_CYCLES - 1)) state_nx = ST_STREAM;
         ST_STREAM: if (last_c) state_nx = ST_DONE;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
      core_rst_nx = (state_nx != ST_CRST);
      busy_nx     = (state_nx == ST_CRST) || (state_nx == ST_STREAM);
      done_nx     = (state_nx == ST_DONE);
   end

   // Status outputs and core-reset timer
   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         core_rst <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rst_cnt  <= '0;
      end else begin
         core_rst <= core_rst_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         rst_cnt  <= (state == ST_CRST) ? rst_cnt + RST_CW'(1) : '0;
      end
   end

   // Verify comparator: prog_out carries the previous pass's copy of the bit being shifted
   always_ff @(posedge prog_clk or negedge rst) begin
      if (!rst) begin
         ver_q        <= 1'b0;
         error        <= 1'b0;
         mismatch_cnt <= '0;
      end else if (start_acc_c) begin
         ver_q        <= verify;
         error        <= 1'b0;
         mismatch_cnt <= '0;
      end else if (prog_en && ver_q && (prog_out != prog_in)) begin
         error <= 1'b1;
         if (mismatch_cnt != {CNT_W{1'b1}}) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      end
   end

   cfg_word_serializer #(
      .NUM_BITS (NUM_BITS),
      .WORD_W   (WORD_W)
   ) u_ser (
      .clk         (prog_clk),
      .rst_n       (rst),
      .clear       (start_acc_c),
      .active      (state == ST_STREAM),
      .active_next (state_nx == ST_STREAM),
      .s_data      (s.s_data),
      .s_valid     (s.s_valid),
      .s_ready     (ready),
      .bit_out     (prog_in),
      .bit_en      (prog_en),
      .last_c      (last_c)
   );

endmodule
